// File: rtl/mam_wb_pkg.sv
// mam_wb_pkg: shared FSM state type and Wishbone CTI/BTE encodings
package mam_wb_pkg;
  typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, RESP} state_e;
  localparam logic [2:0] CLASSIC = 3'b000;
  localparam logic [2:0] INCR = 3'b010;
  localparam logic [2:0] EOB = 3'b111;
  localparam logic [1:0] BTE_LINEAR = 2'b00;
  localparam logic [1:0] BTE_WRAP4 = 2'b01;
  localparam logic [1:0] BTE_WRAP8 = 2'b10;
  localparam logic [1:0] BTE_WRAP16 = 2'b11;
  function automatic logic [1:0] bte_of(input int wrap);
    return wrap == 4 ? BTE_WRAP4 : wrap == 8 ? BTE_WRAP8 : wrap == 16 ? BTE_WRAP16 : BTE_LINEAR;
  endfunction
endpackage

// File: rtl/mam_wb_addr_gen.sv
// mam_wb_addr_gen: beat address sequencing (linear or wrapping) and remaining-beat count
module mam_wb_addr_gen #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 32,
  parameter int WRAP_BEATS = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [13:0]           beats_i,
  input  logic                  adv_i,
  input  logic                  dec_i,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic                  last_o
);
  localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(DATA_WIDTH / 8);
  // only the bits inside one wrap window advance; all-ones mask gives a plain increment
  localparam logic [ADDR_WIDTH-1:0] MASK =
    WRAP_BEATS == 0 ? {ADDR_WIDTH{1'b1}} : ADDR_WIDTH'(WRAP_BEATS * DATA_WIDTH / 8 - 1);
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [13:0] cnt_q, cnt_d;
  assign addr_d = load_i ? addr_i : adv_i ? (addr_q & ~MASK) | ((addr_q + STEP) & MASK) : addr_q;
  assign cnt_d = load_i ? beats_i : dec_i && cnt_q != '0 ? cnt_q - 14'd1 : cnt_q;
  assign addr_o = addr_q;
  assign last_o = cnt_q == 14'd1;
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= '0;
      cnt_q <= '0;
    end else begin
      addr_q <= addr_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/mam_wb_burst_if.sv
// mam_wb_burst_if: request/stream front end issuing Wishbone B4 linear or wrapping bursts
module mam_wb_burst_if
  import mam_wb_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 32,
  parameter int WRAP_BEATS = 0,
  parameter int TIMEOUT = 255
) (
  input  logic                    CLK_I,
  input  logic                    RST_I,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_rw,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic                    req_burst,
  input  logic [13:0]             req_beats,
  input  logic                    write_valid,
  output logic                    write_ready,
  input  logic [DATA_WIDTH-1:0]   write_data,
  input  logic [DATA_WIDTH/8-1:0] write_strb,
  output logic                    read_valid,
  input  logic                    read_ready,
  output logic [DATA_WIDTH-1:0]   read_data,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic                    resp_err,
  output logic                    CYC_O,
  output logic                    STB_O,
  output logic                    WE_O,
  output logic [ADDR_WIDTH-1:0]   ADR_O,
  output logic [DATA_WIDTH-1:0]   DAT_O,
  output logic [DATA_WIDTH/8-1:0] SEL_O,
  output logic [2:0]              CTI_O,
  output logic [1:0]              BTE_O,
  input  logic [DATA_WIDTH-1:0]   DAT_I,
  input  logic                    ACK_I,
  input  logic                    ERR_I
);
  state_e state_q;
  logic rw_q, burst_q, done_q, rvalid_q, err_q;
  logic [DATA_WIDTH-1:0] rbuf_q;
  logic [31:0] tmo_q;
  logic in_wr, in_rd, ack, err, tmo, fail, last, load, dec;
  logic [13:0] beats;
  // done_q drops the bus after the final read beat while the buffer still drains
  assign in_wr = state_q == WRITE;
  assign in_rd = state_q == READ && !done_q;
  assign CYC_O = in_wr || in_rd;
  assign STB_O = in_wr ? write_valid : in_rd && !rvalid_q;
  assign WE_O = CYC_O && rw_q;
  assign DAT_O = in_wr ? write_data : '0;
  assign SEL_O = in_wr ? write_strb : {(DATA_WIDTH/8){in_rd}};
  assign CTI_O = CYC_O && burst_q ? (last ? EOB : INCR) : CLASSIC;
  assign BTE_O = CYC_O ? bte_of(WRAP_BEATS) : BTE_LINEAR;
  assign ack = STB_O && ACK_I && !ERR_I;
  assign err = STB_O && ERR_I;
  assign tmo = TIMEOUT != 0 && STB_O && !ACK_I && !ERR_I && tmo_q == 32'(TIMEOUT - 1);
  assign fail = err || tmo;
  assign req_ready = state_q == IDLE;
  assign load = req_valid && req_ready;
  assign beats = req_burst && req_beats != '0 ? req_beats : 14'd1;
  // an errored write beat is retired so the producer's stream stays aligned with the count
  assign write_ready = in_wr ? ack || err : state_q == DRAIN;
  assign dec = ack || (in_wr && err) || (state_q == DRAIN && write_valid);
  assign read_valid = rvalid_q;
  assign read_data = rbuf_q;
  assign resp_valid = state_q == RESP;
  assign resp_err = resp_valid && err_q;
  mam_wb_addr_gen #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .WRAP_BEATS(WRAP_BEATS)
  ) u_addr_gen (
    .clk(CLK_I),
    .rst(RST_I),
    .load_i(load),
    .addr_i(req_addr),
    .beats_i(beats),
    .adv_i(ack),
    .dec_i(dec),
    .addr_o(ADR_O),
    .last_o(last)
  );
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state_q <= IDLE;
      rw_q <= 1'b0;
      burst_q <= 1'b0;
      done_q <= 1'b0;
      rvalid_q <= 1'b0;
      err_q <= 1'b0;
      rbuf_q <= '0;
      tmo_q <= '0;
    end else begin
      tmo_q <= STB_O && !ACK_I && !ERR_I ? tmo_q + 32'd1 : '0;
      if (read_valid && read_ready) rvalid_q <= 1'b0;
      case (state_q)
        IDLE: if (load) begin
          rw_q <= req_rw;
          burst_q <= req_burst && req_beats != '0;
          done_q <= 1'b0;
          err_q <= 1'b0;
          state_q <= req_rw ? WRITE : READ;
        end
        WRITE: if (fail) begin
          err_q <= 1'b1;
          state_q <= err && last ? RESP : DRAIN;
        end else if (ack && last) state_q <= RESP;
        DRAIN: if (write_valid && last) state_q <= RESP;
        READ: begin
          if (ack) begin
            rbuf_q <= DAT_I;
            rvalid_q <= 1'b1;
          end
          if ((ack && last) || fail) done_q <= 1'b1;
          if (fail) err_q <= 1'b1;
          if (done_q && !rvalid_q) state_q <= RESP;
        end
        RESP: if (resp_ready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
